// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program-memory address sequencer with hardware call/return stack
//
// Purpose: generates the next program-memory fetch address for the 4-bit
// microprocessor. Supports sequential fetch, jumps, conditional jumps on the
// registered zero flag, hold, and subroutine call/return through a small stack.
//
// Optional feature macro: PS_STACK_ERR_EN
//   defined   - call when full jumps without pushing; over/underflow sets a
//               sticky stack_err until reset
//   undefined - call when full overwrites the oldest entry (circular buffer);
//               stack_err is tied to 0
//
// Ports:
//   clk          - system clock, rising edge
//   sync_reset_n - synchronous active-low reset
//   jmp          - unconditional jump to jmp_addr
//   jmp_nz       - jump to jmp_addr when dont_jmp is 0
//   dont_jmp     - registered zero flag from the computational unit
//   call         - push pc+1 and jump to jmp_addr
//   ret          - pop the return address and jump to it
//   hold         - freeze sequencing, re-fetch current pc
//   jmp_addr     - target address from the instruction word
//   pm_addr      - combinational next fetch address
//   pc           - address of the instruction now in the instruction register
//   stack_empty  - stack pointer is 0 (registered)
//   stack_full   - stack pointer equals STACK_DEPTH (registered)
//   stack_err    - sticky over/underflow flag

module program_sequencer #(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input  logic            clk,
  input  logic            sync_reset_n,
  input  logic            jmp,
  input  logic            jmp_nz,
  input  logic            dont_jmp,
  input  logic            call,
  input  logic            ret,
  input  logic            hold,
  input  logic [PC_W-1:0] jmp_addr,
  output logic [PC_W-1:0] pm_addr,
  output logic [PC_W-1:0] pc,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] wr_idx_nxt;
  logic [IDX_W-1:0] top_idx;
  logic [PC_W-1:0]  pc_inc;
  logic             active;
  logic             ret_ok;
  logic             do_pop;
  logic             push_req;
  logic             do_push;
  logic             err_set;

  always_comb begin
    pc_inc   = pc + PC_W'(1);
    // Top of stack is the slot just below the write index.
    top_idx  = wr_idx - IDX_W'(1);
    active   = sync_reset_n && !hold;
    ret_ok   = ret && !stack_empty;
    do_pop   = active && ret_ok;
    // A ret that wins over call suppresses the push entirely.
    push_req = active && call && !ret_ok;
`ifdef PS_STACK_ERR_EN
    do_push  = push_req && !stack_full;
    err_set  = (push_req && stack_full) || (active && ret && stack_empty);
`else
    do_push  = push_req;
    err_set  = 1'b0;
`endif
  end

  always_comb begin
    pm_addr = pc_inc;
    if (!sync_reset_n)           pm_addr = RESET_VEC;
    else if (hold)               pm_addr = pc;
    else if (ret_ok)             pm_addr = stack_mem[top_idx];
    else if (call)               pm_addr = jmp_addr;
    else if (jmp)                pm_addr = jmp_addr;
    else if (jmp_nz && !dont_jmp) pm_addr = jmp_addr;
  end

  always_comb begin
    sp_nxt     = sp;
    wr_idx_nxt = wr_idx;
    if (do_pop) begin
      sp_nxt     = sp - SP_W'(1);
      wr_idx_nxt = wr_idx - IDX_W'(1);
    end else if (do_push) begin
      // Pointer saturates at full; write index keeps wrapping so an
      // overflowing push replaces the oldest entry.
      if (!stack_full) sp_nxt = sp + SP_W'(1);
      wr_idx_nxt = wr_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    pc <= pm_addr;
    if (!sync_reset_n) begin
      sp          <= '0;
      wr_idx      <= '0;
      stack_empty <= 1'b1;
      stack_full  <= 1'b0;
    end else begin
      sp          <= sp_nxt;
      wr_idx      <= wr_idx_nxt;
      stack_empty <= (sp_nxt == '0);
      stack_full  <= (sp_nxt == SP_W'(STACK_DEPTH));
    end
  end

  // Stack contents need no reset; do_push is already gated by reset.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[wr_idx] <= pc_inc;
  end

`ifdef PS_STACK_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!sync_reset_n) err_q <= 1'b0;
    else if (err_set)  err_q <= 1'b1;
  end
  assign stack_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_set;
  assign stack_err  = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed self-checking bench for program_sequencer

`timescale 1ns/1ps

module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset_n;
    logic       jmp, jmp_nz, dont_jmp, call, ret, hold;
    logic [7:0] jmp_addr;
    logic [7:0] pm_addr, pc;
    logic       stack_empty, stack_full, stack_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    program_sequencer #(.PC_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clk         (clk),
        .sync_reset_n(sync_reset_n),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .call        (call),
        .ret         (ret),
        .hold        (hold),
        .jmp_addr    (jmp_addr),
        .pm_addr     (pm_addr),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [7:0] a);
        jmp = 1'b1; jmp_addr = a;
        tick();
        jmp = 1'b0;
    endtask

`ifdef PS_STACK_ERR_EN
    localparam logic       ERR_EN = 1'b1;
    localparam logic [7:0] R0 = 8'h71, R1 = 8'h61, R2 = 8'h51, R3 = 8'h22;
`else
    localparam logic       ERR_EN = 1'b0;
    localparam logic [7:0] R0 = 8'h91, R1 = 8'h71, R2 = 8'h61, R3 = 8'h51;
`endif

    initial begin
        logic [7:0] exp_ret [4];
        logic [7:0] tgt     [5];
        exp_ret = '{R0, R1, R2, R3};
        tgt     = '{8'h50, 8'h60, 8'h70, 8'h90, 8'hA0};

        sync_reset_n = 1'b0;
        {jmp, jmp_nz, dont_jmp, call, ret, hold} = '0;
        jmp_addr = 8'h00;

        #1;
        check("rst_pm_addr", pm_addr, 8'h00);
        tick(); tick(); tick();
        check("rst_pc", pc, 8'h00);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_err", stack_err, 1'b0);
        sync_reset_n = 1'b1;
        #1;
        check("rel_pm_addr", pm_addr, 8'h01);
        tick();
        check("seq_pc1", pc, 8'h01);
        tick();
        check("seq_pc2", pc, 8'h02);

        jump_to(8'h10);
        check("jmp_pc", pc, 8'h10);
        jmp_nz = 1'b1; dont_jmp = 1'b0; jmp_addr = 8'h40;
        #1;
        check("jnz_taken_pm", pm_addr, 8'h40);
        tick();
        check("jnz_taken_pc", pc, 8'h40);
        jmp_nz = 1'b0;
        jump_to(8'h10);
        jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 8'h40;
        tick();
        check("jnz_fall_pc", pc, 8'h11);
        jmp_nz = 1'b0; dont_jmp = 1'b0;

        jump_to(8'h20);
        call = 1'b1; jmp_addr = 8'h80;
        tick();
        call = 1'b0;
        check("call_pc", pc, 8'h80);
        check("call_not_empty", stack_empty, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("body_pc", pc, 8'h85);
        ret = 1'b1;
        #1;
        check("ret_pm", pm_addr, 8'h21);
        tick();
        ret = 1'b0;
        check("ret_pc", pc, 8'h21);
        check("ret_empty", stack_empty, 1'b1);

        call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jmp_addr = tgt[i];
            tick();
            if (i == 3) check("full_after_4", stack_full, 1'b1);
        end
        call = 1'b0;
        check("call5_pc", pc, 8'hA0);
        check("call5_err", stack_err, ERR_EN);
        check("call5_full", stack_full, 1'b1);
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nested_ret_pc", pc, exp_ret[i]);
        end
        check("nested_empty", stack_empty, 1'b1);
        tick();
        check("ret_empty_fall", pc, R3 + 8'h01);
        ret = 1'b0;
        check("ret_empty_err", stack_err, ERR_EN);

        jump_to(8'hFF);
        tick();
        check("wrap_pc", pc, 8'h00);
        hold = 1'b1; call = 1'b1; jmp_addr = 8'h33;
        #1;
        check("hold_pm", pm_addr, 8'h00);
        tick();
        check("hold_pc1", pc, 8'h00);
        tick();
        check("hold_pc2", pc, 8'h00);
        check("hold_empty", stack_empty, 1'b1);
        hold = 1'b0; call = 1'b0;

        jump_to(8'h30);
        call = 1'b1; jmp_addr = 8'h77; sync_reset_n = 1'b0;
        #1;
        check("rstcall_pm", pm_addr, 8'h00);
        tick();
        check("rstcall_pc", pc, 8'h00);
        check("rstcall_empty", stack_empty, 1'b1);
        check("rstcall_err", stack_err, 1'b0);
        call = 1'b0; sync_reset_n = 1'b1;
        tick();
        check("post_rst_pc", pc, 8'h01);
        check("post_rst_empty", stack_empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Generates the program-memory address for the 4-bit microprocessor.
- Sits upstream of the instruction register and decoder that drive the computational unit.
- Consumes the computational unit's registered zero flag (r_eq_0) for conditional jumps.
- Adds a hardware call/return stack for subroutines.
- Program memory is a synchronous ROM: pm_addr issued in cycle N returns its instruction at the clock edge ending cycle N.

Parameters:
- PC_W, 8: program-counter and address width in bits.
- STACK_DEPTH, 4: number of return-address entries; must be a power of two, at least 2.
- RESET_VEC, 0: address fetched during and immediately after reset.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- sync_reset_n, input, 1: synchronous, active-low reset.
- jmp, input, 1: unconditional jump to jmp_addr (from decoder).
- jmp_nz, input, 1: jump to jmp_addr if dont_jmp is 0.
- dont_jmp, input, 1: r_eq_0 from the computational unit.
- call, input, 1: push return address, jump to jmp_addr.
- ret, input, 1: pop the return address and jump to it.
- hold, input, 1: freeze sequencing; re-fetch current pc.
- jmp_addr, input, PC_W: target address from the instruction word.
- pm_addr, output, PC_W: combinational next fetch address to program memory.
- pc, output, PC_W: registered address of the instruction now in the instruction register.
- stack_empty, output, 1: stack pointer is 0.
- stack_full, output, 1: stack pointer equals STACK_DEPTH.
- stack_err, output, 1: sticky over/underflow flag (see Optional Feature).

Behaviour:
- The pc register always loads pm_addr at each edge.
- pm_addr priority, highest first:
  1. !sync_reset_n: pm_addr = RESET_VEC.
  2. hold: pm_addr = pc.
  3. ret and stack not empty: pm_addr = top of stack.
  4. call: pm_addr = jmp_addr.
  5. jmp: pm_addr = jmp_addr.
  6. jmp_nz and dont_jmp == 0: pm_addr = jmp_addr.
  7. Otherwise: pm_addr = pc + 1, modulo 2^PC_W (all-ones wraps to 0).
- Reset (sync_reset_n low at an edge):
  - pc = RESET_VEC, stack pointer = 0, stack_err = 0.
  - stack_empty = 1, stack_full = 0.
  - Stack contents are don't-care.
  - Reset mid-call or mid-return discards the push or pop.
- Call:
  - Pushes pc + 1 (wrapped) at the edge; pointer increments.
  - Latency: the target instruction is in the IR one edge after call is sampled.
- Ret:
  - Pops at the edge; pointer decrements.
  - Ret on an empty stack falls through to the next priority level; pointer unchanged.
- Call and ret together: ret wins; the stack pops only, no push.
- hold suppresses all stack activity and jumps.
- jmp_nz with dont_jmp = 1 falls through to pc + 1.
- stack_empty and stack_full are registered decodes of the pointer and are valid the cycle after each push or pop.
- Call when full: follows the Optional Feature rules.

Optional Feature:
- Macro: PS_STACK_ERR_EN.
- Defined:
  - Call when full still jumps to jmp_addr, but no push occurs and the pointer holds.
  - Ret when empty is handled as in Behaviour.
  - Either event sets stack_err = 1 on that edge; it stays set until reset.
- Undefined:
  - stack_err is tied to 0.
  - Call when full overwrites the oldest entry: circular buffer, pointer saturates at STACK_DEPTH, write index wraps.
  - A subsequent ret returns the most recent entries in LIFO order.

Test Plan:
- Reset held 3 cycles, then released with no control inputs: pm_addr = 0x00 during reset; pc = 0x00, 0x01, 0x02 on successive edges; stack_empty = 1.
- pc = 0x10, jmp_nz = 1, jmp_addr = 0x40:
  - dont_jmp = 0 gives next pc = 0x40.
  - Repeat with dont_jmp = 1: next pc = 0x11.
- pc = 0x20, call to 0x80, then ret at 0x85: pc sequence 0x80…0x85, then 0x21; stack_empty returns to 1.
- Nested calls deeper than STACK_DEPTH = 4 (5 calls):
  - With PS_STACK_ERR_EN: stack_err = 1 after the fifth call; the fifth call still reaches jmp_addr.
  - Without it: stack_err = 0, and four rets return to the four most recent return addresses.
- pc = 0xFF, no control: next pc = 0x00. Then hold = 1 for 2 cycles with call = 1: pc stays 0x00 and the stack pointer is unchanged.
- Reset asserted on the same edge as call = 1 at pc = 0x30: pc = 0x00, stack_empty = 1, stack_err = 0.
